// File: rtl/trivium_ctrl_if.sv
// Byte-stream handshake bundle between the host side and trivium_ctrl.
// The host (master) offers plaintext and accepts ciphertext. The controller
// (slave) meters both directions with valid/ready.
interface trivium_ctrl_if;
  logic [7:0] data;
  logic       strob_data;
  logic       data_rdy;
  logic [7:0] stream;
  logic       stream_vld;
  logic       stream_rdy;

  modport master (
    output data, strob_data, stream_rdy,
    input  data_rdy, stream, stream_vld
  );

  modport slave (
    input  data, strob_data, stream_rdy,
    output data_rdy, stream, stream_vld
  );
endinterface

// File: rtl/trivium_ctrl.sv
// Sequencing controller for the Trivium keystream core.
// The block does the following:
//   - collects the 80-bit key serially (MSB first);
//   - captures the IV on start;
//   - pulses the core through load and warm-up;
//   - meters byte-wide encryption (stream = data ^ core_z) with valid/ready.
// The core itself holds all cipher state; everything here is sequencing.
//
// Optional feature: define TRIVIUM_REKEY_LIMIT_EN to count encrypted bytes.
// In that build, after BYTES_PER_KEY bytes the block forces a new key via
// the REKEY state. When the macro is not defined, the byte counter and REKEY
// are absent and rekey_req stays 0.
module trivium_ctrl #(
  parameter int INIT_STEPS    = 144,
  parameter int BYTES_PER_KEY = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key,
  input  logic          strob_key,
  input  logic [79:0]   iv,
  input  logic          start,
  trivium_ctrl_if.slave bus,
  output logic          core_load,
  output logic [79:0]   core_key,
  output logic [79:0]   core_iv,
  output logic          core_step,
  input  logic [7:0]    core_z,
  output logic          key_ok,
  output logic          busy,
  output logic          rekey_req,
  output logic          err
);

  localparam int STEP_W = (INIT_STEPS > 1) ? $clog2(INIT_STEPS) : 1;

  // The byte counter is 9 bits wide and INIT needs at least one step.
  // Reject any parameter set that breaks these assumptions.
  if (INIT_STEPS < 1 || BYTES_PER_KEY < 1 || BYTES_PER_KEY > 256) begin : g_bad_params
    $error("trivium_ctrl: INIT_STEPS or BYTES_PER_KEY out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    KEY_SHIFT,
    KEY_DONE,
    LOAD,
    INIT,
    READY,
    HOLD,
    REKEY
  } state_t;

  state_t              state, state_next;
  logic [6:0]          bit_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [7:0]          stream_q;

  logic do_shift;
  logic restart_bits;
  logic key_full;
  logic capture_iv;
  logic take_data;
  logic enter_rekey;
  logic bad_input;

`ifdef TRIVIUM_REKEY_LIMIT_EN
  logic [8:0] byte_cnt;
  logic [8:0] byte_cnt_inc;
  logic       accept_byte;
  logic       clear_bytes;

  assign byte_cnt_inc = (byte_cnt == 9'(BYTES_PER_KEY)) ? byte_cnt : byte_cnt + 9'd1;
  assign accept_byte  = (state == HOLD) && bus.stream_rdy;
  assign clear_bytes  = (state == REKEY) && strob_key;
`endif

  assign bus.stream = stream_q;

  // State register; reset drops straight back to IDLE from anywhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode, per-cycle action strobes and the Moore/Mealy outputs.
  // A protocol violation only ignores the offending input; the other inputs
  // in the same cycle are still honoured.
  always_comb begin
    state_next     = state;
    do_shift       = 1'b0;
    restart_bits   = 1'b0;
    key_full       = 1'b0;
    capture_iv     = 1'b0;
    take_data      = 1'b0;
    enter_rekey    = 1'b0;
    bad_input      = 1'b0;
    core_load      = 1'b0;
    core_step      = 1'b0;
    busy           = 1'b0;
    rekey_req      = 1'b0;
    bus.data_rdy   = 1'b0;
    bus.stream_vld = 1'b0;

    if (start && state != KEY_DONE)       bad_input = 1'b1;
    if (bus.strob_data && state != READY) bad_input = 1'b1;

    case (state)
      IDLE, REKEY: begin
        rekey_req = (state == REKEY);
        if (strob_key) begin
          do_shift     = 1'b1;
          restart_bits = 1'b1;
          state_next   = KEY_SHIFT;
        end
      end
      KEY_SHIFT: begin
        if (strob_key) begin
          do_shift = 1'b1;
          if (bit_cnt == 7'd79) begin
            key_full   = 1'b1;
            state_next = KEY_DONE;
          end
        end
      end
      KEY_DONE: begin
        if (strob_key) bad_input = 1'b1;
        if (start) begin
          capture_iv = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        core_load  = 1'b1;
        busy       = 1'b1;
        if (strob_key) bad_input = 1'b1;
        state_next = INIT;
      end
      INIT: begin
        core_step = 1'b1;
        busy      = 1'b1;
        if (strob_key) bad_input = 1'b1;
        if (step_cnt == STEP_W'(INIT_STEPS - 1)) state_next = READY;
      end
      READY: begin
        bus.data_rdy = 1'b1;
        if (strob_key) bad_input = 1'b1;
        if (bus.strob_data) begin
          take_data  = 1'b1;
          core_step  = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        bus.stream_vld = 1'b1;
        if (strob_key) bad_input = 1'b1;
        if (bus.stream_rdy) begin
`ifdef TRIVIUM_REKEY_LIMIT_EN
          if (byte_cnt_inc == 9'(BYTES_PER_KEY)) begin
            enter_rekey = 1'b1;
            state_next  = REKEY;
          end else begin
            state_next  = READY;
          end
`else
          state_next = READY;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Key/IV registers, counters, the held ciphertext byte and the sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_key <= '0;
      core_iv  <= '0;
      bit_cnt  <= '0;
      step_cnt <= '0;
      stream_q <= '0;
      key_ok   <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (do_shift) core_key <= {core_key[78:0], key};

      if (restart_bits)  bit_cnt <= 7'd1;
      else if (do_shift) bit_cnt <= bit_cnt + 7'd1;

      if (key_full)         key_ok <= 1'b1;
      else if (enter_rekey) key_ok <= 1'b0;

      if (capture_iv) core_iv <= iv;

      if (core_load)          step_cnt <= '0;
      else if (state == INIT) step_cnt <= step_cnt + STEP_W'(1);

      if (take_data) stream_q <= bus.data ^ core_z;

      if (bad_input) err <= 1'b1;
    end
  end

`ifdef TRIVIUM_REKEY_LIMIT_EN
  // Bytes encrypted under the current key; a fresh key restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             byte_cnt <= '0;
    else if (clear_bytes) byte_cnt <= '0;
    else if (accept_byte) byte_cnt <= byte_cnt_inc;
  end
`endif

endmodule

// File: tb/tb_trivium_ctrl.sv
// Self-checking bench for trivium_ctrl.
// The bench models the core keystream byte (core_z) directly. Every expected
// ciphertext byte is queued when its plaintext is accepted, then popped when
// the controller hands the byte downstream. BYTES_PER_KEY is 4, so the
// TRIVIUM_REKEY_LIMIT_EN build reaches REKEY quickly.
module tb_trivium_ctrl;

  localparam int INIT_STEPS = 144;
  localparam int BPK        = 4;

  localparam logic [79:0] KEY_A = 80'h0123_4567_89AB_CDEF_0123;
  localparam logic [79:0] KEY_B = 80'hA5C3_0F1E_D2B4_9687_7E5D;
  localparam logic [79:0] IV_A  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] IV_B  = 80'h1357_9BDF_2468_ACE0_1122;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key = 1'b0;
  logic        strob_key = 1'b0;
  logic        start = 1'b0;
  logic [79:0] iv = '0;
  logic [7:0]  core_z = '0;
  logic        core_load, core_step, key_ok, busy, rekey_req, err;
  logic [79:0] core_key, core_iv;

  trivium_ctrl_if bus();

  trivium_ctrl #(
    .INIT_STEPS   (INIT_STEPS),
    .BYTES_PER_KEY(BPK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .strob_key(strob_key),
    .iv       (iv),
    .start    (start),
    .bus      (bus),
    .core_load(core_load),
    .core_key (core_key),
    .core_iv  (core_iv),
    .core_step(core_step),
    .core_z   (core_z),
    .key_ok   (key_ok),
    .busy     (busy),
    .rekey_req(rekey_req),
    .err      (err)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         last_wait;
  logic [7:0] sb[$];

  // Hard time limit so a stuck handshake can never hang the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_core_load"}, core_load, 0);
    checkOutput({tag, "_core_step"}, core_step, 0);
    checkOutput({tag, "_key_ok"}, key_ok, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_rekey_req"}, rekey_req, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_data_rdy"}, bus.data_rdy, 0);
    checkOutput({tag, "_stream_vld"}, bus.stream_vld, 0);
    checkOutput({tag, "_stream"}, bus.stream, 0);
    checkOutput({tag, "_core_key"}, core_key, 0);
    checkOutput({tag, "_core_iv"}, core_iv, 0);
  endtask

  task automatic doReset;
    rst = 1'b0;
    repeat (3) tick;
    checkIdle("reset");
    rst = 1'b1;
    tick;
  endtask

  task automatic shiftKey(input logic [79:0] k);
    for (int i = 79; i >= 0; i--) begin
      if (i % 17 == 5) begin
        strob_key = 1'b0;
        tick;
      end
      key       = k[i];
      strob_key = 1'b1;
      if (i == 0) checkOutput("key_ok_before_last", key_ok, 0);
      tick;
      if (i == 79) checkOutput("rekey_req_after_first_bit", rekey_req, 0);
    end
    strob_key = 1'b0;
    key       = 1'b0;
    checkOutput("key_ok", key_ok, 1);
    checkOutput("core_key", core_key, k);
  endtask

  // Cycle n counts from the accepted start (n = 0). strob_key is poked at
  // cycle poke_at to exercise the INIT error path.
  task automatic startAndInit(input logic [79:0] ivv, input int poke_at);
    int n;
    int steps;
    int loads;
    iv    = ivv;
    start = 1'b1;
    tick;
    start = 1'b0;
    iv    = ~ivv;
    steps = 0;
    loads = 0;
    n     = 1;
    while (!bus.data_rdy && n < 400) begin
      if (core_step) steps++;
      if (core_load) loads++;
      strob_key = (n == poke_at);
      key       = 1'b1;
      tick;
      n++;
    end
    strob_key = 1'b0;
    key       = 1'b0;
    checkOutput("init_load_pulses", loads, 1);
    checkOutput("init_step_pulses", steps, INIT_STEPS);
    checkOutput("data_rdy_cycle", n, INIT_STEPS + 2);
    checkOutput("core_iv", core_iv, ivv);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] z, input int hold);
    int w;
    w = 0;
    while (!bus.data_rdy && w < 10) begin
      tick;
      w++;
    end
    last_wait = w;
    checkOutput("data_rdy_wait", bus.data_rdy, 1);
    bus.data       = d;
    core_z         = z;
    bus.strob_data = 1'b1;
    #1;
    checkOutput("core_step_on_data", core_step, 1);
    sb.push_back(d ^ z);
    tick;
    bus.strob_data = 1'b0;
    bus.data       = ~d;
    core_z         = ~z;
    checkOutput("stream_vld_rise", bus.stream_vld, 1);
    checkOutput("data_rdy_in_hold", bus.data_rdy, 0);
    for (int i = 0; i < hold; i++) begin
      tick;
      checkOutput("hold_stream_vld", bus.stream_vld, 1);
      checkOutput("hold_stream", bus.stream, sb[0]);
      checkOutput("hold_data_rdy", bus.data_rdy, 0);
      checkOutput("hold_core_step", core_step, 0);
    end
    bus.stream_rdy = 1'b1;
    checkOutput("stream", bus.stream, sb.pop_front());
    tick;
    bus.stream_rdy = 1'b0;
    checkOutput("stream_vld_fall", bus.stream_vld, 0);
  endtask

  initial begin
    bus.data       = '0;
    bus.strob_data = 1'b0;
    bus.stream_rdy = 1'b0;

    doReset();
    shiftKey(KEY_A);
    checkOutput("err_before_start", err, 0);

    startAndInit(IV_A, 50);
    checkOutput("err_strob_key_in_init", err, 1);
    checkOutput("core_key_after_poke", core_key, KEY_A);

    start = 1'b1;
    #1;
    checkOutput("no_step_on_bad_start", core_step, 0);
    tick;
    start = 1'b0;
    checkOutput("ready_after_bad_start", bus.data_rdy, 1);
    checkOutput("no_load_on_bad_start", core_load, 0);

    applyStimulus(8'h5A, 8'h3C, 5);
    checkOutput("tp_5A_xor_3C_queue_drained", sb.size(), 0);

`ifdef TRIVIUM_REKEY_LIMIT_EN
    for (int b = 1; b < BPK; b++) begin
      applyStimulus(8'(b * 37 + 5), 8'(b * 91), 0);
      checkOutput("throughput_wait", last_wait, 0);
    end
    checkOutput("rekey_req_at_limit", rekey_req, 1);
    checkOutput("data_rdy_at_limit", bus.data_rdy, 0);
    checkOutput("key_ok_at_limit", key_ok, 0);
    bus.strob_data = 1'b1;
    tick;
    bus.strob_data = 1'b0;
    checkOutput("rekey_holds_on_data", rekey_req, 1);
    checkOutput("no_stream_in_rekey", bus.stream_vld, 0);
    shiftKey(KEY_B);
    checkOutput("rekey_req_after_key", rekey_req, 0);
    startAndInit(IV_B, -1);
    applyStimulus(8'hC3, 8'h81, 1);
    checkOutput("rekey_req_after_new_key", rekey_req, 0);
`else
    for (int b = 1; b <= 5; b++) begin
      applyStimulus(8'(b * 37 + 5), 8'(b * 91), 0);
      checkOutput("throughput_wait", last_wait, 0);
      checkOutput("rekey_req_unlimited", rekey_req, 0);
    end
    checkOutput("data_rdy_past_limit", bus.data_rdy, 1);
    checkOutput("key_ok_past_limit", key_ok, 1);
`endif

    // Abort partway through warm-up, then prove a clean full reload works.
    doReset();
    shiftKey(KEY_B);
    begin : abort_init
      int steps;
      int n;
      iv    = IV_B;
      start = 1'b1;
      tick;
      start = 1'b0;
      steps = 0;
      n     = 0;
      while (steps < 70 && n < 200) begin
        if (core_step) steps++;
        tick;
        n++;
      end
      checkOutput("steps_before_abort", steps, 70);
      #2 rst = 1'b0;
      #1;
      checkIdle("abort");
      tick;
      tick;
      rst = 1'b1;
      tick;
    end
    checkIdle("after_abort");
    shiftKey(KEY_A);
    startAndInit(IV_A, -1);
    applyStimulus(8'h96, 8'h0F, 2);
    checkOutput("err_clean_reload", err, 0);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
